shift_scheduler: RTL and testbench

Controller that shares one 8-bit one-hot-amount left shifter (data D, one-hot amount N, result W) between two requesters.
- Arbitrates round-robin between the requesters.
- Converts each request's binary shift amount into one or more one-hot passes of at most 7 positions, feeding each result back as the next pass input.
- Returns the final word on a valid/ready response channel.
- Sits between the shifter datapath and its clients; the shifter itself stays outside this block.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/shift_scheduler.sv | 131 +++++++++++++
 tb/tb_shift_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types, constants and helpers for the shift scheduler slice.
package shift_pkg;

    // Width of the binary shift amount carried by each request.
    localparam int unsigned AMT_W = 4;

    // Largest single-pass shift; matches the highest one-hot input of the shifter.
    localparam int unsigned MAX_STEP = 7;

    // Scheduler control states.
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // One-hot select for the external shifter: bit k closes the "shift by k" switch.
    function automatic logic [7:0] onehot8(input logic [2:0] step);
        return 8'h01 << step;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_id,
    output logic grant_valid,
    output logic grant_id
);

    // Pure combinational grant; the caller owns last_id and updates it on acceptance.
    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = 1'b0;
        if (valid0 && valid1) begin
            grant_id = ~last_id;
        end else if (valid1) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/shift_scheduler.sv
// Shares one external 8-bit one-hot-amount shifter between two requesters. A request's
// binary amount is broken into passes of at most MAX_STEP positions, each pass result is
// fed back as the next pass input, and the final word is returned on a valid/ready channel.
module shift_scheduler #(
    parameter int unsigned AMT_W    = shift_pkg::AMT_W,
    parameter int unsigned MAX_STEP = shift_pkg::MAX_STEP
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             req1_ready,

    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready,

    output logic [7:0]       sh_d,
    output logic [7:0]       sh_n,
    input  logic [7:0]       sh_w
);

    import shift_pkg::*;

    // Per-pass ceiling expressed in the amount's own width for compare and subtract.
    localparam logic [AMT_W-1:0] MaxStep = AMT_W'(MAX_STEP);

    state_e           state_q, state_d;
    logic [7:0]       work_q, work_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             id_q, id_d;
    logic             last_id_q, last_id_d;

    logic             grant_valid;
    logic             grant_id;
    logic [AMT_W-1:0] step;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_id     (last_id_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Size of the pass applied this cycle: the whole remainder once it fits, else a full step.
    always_comb begin
        step = (rem_q > MaxStep) ? MaxStep : rem_q;
    end

    // Next-state and output decode; every output is quiet unless its state drives it.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        rem_d      = rem_q;
        id_d       = id_q;
        last_id_d  = last_id_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = 8'h00;
        rsp_id     = 1'b0;
        sh_d       = 8'h00;
        sh_n       = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    work_d     = grant_id ? req1_data : req0_data;
                    rem_d      = grant_id ? req1_amt : req0_amt;
                    id_d       = grant_id;
                    last_id_d  = grant_id;
                    state_d    = StShift;
                end
            end

            StShift: begin
                // Amount 0 still makes one identity pass with sh_n = 8'h01.
                sh_d   = work_q;
                sh_n   = onehot8(step[2:0]);
                work_d = sh_w;
                rem_d  = rem_q - step;
                if (rem_q <= MaxStep) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                // No acceptance here: the arbiter is only consulted from StIdle.
                rsp_valid = 1'b1;
                rsp_data  = work_q;
                rsp_id    = id_q;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            work_q    <= 8'h00;
            rem_q     <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
        end
    end

endmodule

// File: tb/tb_shift_scheduler.sv
// Self-checking bench for shift_scheduler with a behavioural one-hot shifter and a
// response scoreboard fed at request acceptance.
module tb_shift_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic [3:0] req0_amt, req1_amt;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] sh_d, sh_n, sh_w;

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] exp_data_q [$];
    logic       exp_id_q   [$];

    always #5 clk = ~clk;

    // External shifter: W = D << k for the single closed switch k, 0 when none conducts.
    always_comb begin
        sh_w = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (sh_n[k]) sh_w = 8'(sh_d << k);
        end
    end

    shift_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .sh_d       (sh_d),
        .sh_n       (sh_n),
        .sh_w       (sh_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_shift(input logic [7:0] d, input logic [3:0] a);
        logic [15:0] wide;
        wide = {8'h00, d} << a;
        return wide[7:0];
    endfunction

    // Scoreboard: push on acceptance, pop on response handshake; reset discards pending work.
    always @(negedge clk) begin
        if (rst) begin
            exp_data_q.delete();
            exp_id_q.delete();
        end else begin
            if (req0_valid && req0_ready) begin
                exp_data_q.push_back(model_shift(req0_data, req0_amt));
                exp_id_q.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                exp_data_q.push_back(model_shift(req1_data, req1_amt));
                exp_id_q.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                check_eq("sb_pending", 32'(exp_data_q.size() > 0), 32'd1);
                if (exp_data_q.size() > 0) begin
                    check_eq("rsp_data", 32'(rsp_data), 32'(exp_data_q.pop_front()));
                    check_eq("rsp_id", 32'(rsp_id), 32'(exp_id_q.pop_front()));
                end
            end
            check_eq("sh_n_onehot0", 32'($countones(sh_n) <= 1), 32'd1);
        end
    end

    // Present a request, wait (bounded) for its ready pulse, then drop valid after the edge.
    task automatic send(input bit who, input logic [7:0] d, input logic [3:0] a);
        bit got;
        got = 1'b0;
        if (!who) begin
            req0_data = d; req0_amt = a; req0_valid = 1'b1;
        end else begin
            req1_data = d; req1_amt = a; req1_valid = 1'b1;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = who ? req1_ready : req0_ready;
        end
        check_eq("send_grant", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (!who) req0_valid = 1'b0;
        else      req1_valid = 1'b0;
    endtask

    // Single transaction: first-pass select, response exactly after the expected pass count.
    task automatic run_one(input bit who, input logic [7:0] d, input logic [3:0] a,
                           input logic [7:0] first_n);
        int passes;
        passes = (a == 0) ? 1 : (int'(a) + 6) / 7;
        send(who, d, a);
        for (int p = 0; p < passes; p++) begin
            @(negedge clk);
            if (p == 0) check_eq("first_sh_n", 32'(sh_n), 32'(first_n));
            check_eq("rsp_early", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        check_eq("rsp_latency", 32'(rsp_valid), 32'd1);
        check_eq("rsp_owner", 32'(rsp_id), 32'(who));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] nseq [3];
        logic [7:0] dseq [3];
        bit         got, prev_grant, exp_id;
        int         grants;

        nseq = '{8'h80, 8'h80, 8'h02};
        dseq = '{8'hFF, 8'h80, 8'h00};
        req0_valid = 1'b0; req0_data = 8'h00; req0_amt = 4'd0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 4'd0;
        rsp_ready  = 1'b1;

        // Reset values.
        #2;
        check_eq("rst_req0_ready", 32'(req0_ready), 32'd0);
        check_eq("rst_req1_ready", 32'(req1_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_sh_d", 32'(sh_d), 32'd0);
        check_eq("rst_sh_n", 32'(sh_n), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("idle_sh_n", 32'(sh_n), 32'd0);
        @(posedge clk); #1;

        // Single-pass cases: amt 3, amt 7, amt 0 identity.
        run_one(1'b0, 8'h81, 4'd3, 8'h08);
        run_one(1'b1, 8'h01, 4'd7, 8'h80);
        run_one(1'b1, 8'hA5, 4'd0, 8'h01);

        // Amount 15: three passes 7,7,1 with feedback through sh_d.
        send(1'b0, 8'hFF, 4'd15);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("amt15_sh_n", 32'(sh_n), 32'(nseq[i]));
            check_eq("amt15_sh_d", 32'(sh_d), 32'(dseq[i]));
            check_eq("amt15_early", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        check_eq("amt15_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("amt15_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clk); #1;

        // Reset after the first pass of a 3-pass request.
        send(1'b0, 8'hFF, 4'd15);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_eq("midrst_sh_n", 32'(sh_n), 32'd0);
        check_eq("midrst_sh_d", 32'(sh_d), 32'd0);
        check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("midrst_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Both constantly valid: strict alternation starting with requester 0.
        req0_data = 8'h11; req0_amt = 4'd1; req0_valid = 1'b1;
        req1_data = 8'h22; req1_amt = 4'd1; req1_valid = 1'b1;
        grants = 0; prev_grant = 1'b0; exp_id = 1'b0;
        for (int i = 0; i < 100 && grants < 4; i++) begin
            @(negedge clk);
            if (prev_grant) check_eq("ready_pulse", 32'(req0_ready | req1_ready), 32'd0);
            prev_grant = req0_ready | req1_ready;
            if (prev_grant) begin
                check_eq("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
                check_eq("rr_order", 32'(req1_ready), 32'(exp_id));
                exp_id = ~exp_id;
                grants++;
            end
        end
        check_eq("rr_grants", 32'(grants), 32'd4);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Response stall: everything holds, nothing is accepted, shifter idle.
        rsp_ready = 1'b0;
        send(1'b0, 8'h81, 4'd3);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        check_eq("stall_rsp_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        req1_data = 8'h21; req1_amt = 4'd2; req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(rsp_valid), 32'd1);
            check_eq("stall_data", 32'(rsp_data), 32'h08);
            check_eq("stall_id", 32'(rsp_id), 32'd0);
            check_eq("stall_ready", 32'(req0_ready | req1_ready), 32'd0);
            check_eq("stall_sh_n", 32'(sh_n), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("no_accept_on_rsp", 32'(req1_ready), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req1_ready;
        end
        check_eq("post_stall_grant", 32'(got), 32'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        check_eq("sb_drained", 32'(exp_data_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
